radio_tx_framer: RTL



---
 rtl/radio_tx_framer_if.sv | 21 ++
 rtl/radio_tx_framer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/radio_tx_framer_if.sv
// Controller <-> framer signal bundle.
//   master : node controller (drives enable/send/data, sees status and line)
//   slave  : radio_tx_framer
// radio_enable/radio_send/radio_tx_data : block enable, byte strobe, payload byte
// radio_busy : flow control back to the controller
// tx_bit/tx_active/frame_done/overflow : serial line and frame status
interface radio_tx_framer_if;
  logic       radio_enable;
  logic       radio_send;
  logic [7:0] radio_tx_data;
  logic       radio_busy;
  logic       tx_bit;
  logic       tx_active;
  logic       frame_done;
  logic       overflow;

  modport master (output radio_enable, radio_send, radio_tx_data,
                  input  radio_busy, tx_bit, tx_active, frame_done, overflow);
  modport slave  (input  radio_enable, radio_send, radio_tx_data,
                  output radio_busy, tx_bit, tx_active, frame_done, overflow);
endinterface

// File: rtl/radio_tx_framer.sv
// Radio TX framer: buffers payload bytes, then sends
// PREAMBLE, SYNC, LEN, payload..., CHK serially LSB-first, each bit held
// CLKS_PER_BIT clocks. CHK = LEN ^ all payload bytes.
// Ports: clk, rst_n (async active-low), rif (slave side of radio_tx_framer_if).
module radio_tx_framer #(
  parameter int         PAYLOAD_MAX  = 16,
  parameter int         CLKS_PER_BIT = 8,
  parameter int         IDLE_GAP     = 4,
  parameter logic [7:0] PREAMBLE     = 8'hAA,
  parameter logic [7:0] SYNC         = 8'h7E
) (
  input  logic              clk,
  input  logic              rst_n,
  radio_tx_framer_if.slave  rif
);
  localparam int CW = $clog2(PAYLOAD_MAX + 1);
  localparam int IW = (PAYLOAD_MAX > 1) ? $clog2(PAYLOAD_MAX) : 1;
  localparam int GW = $clog2(IDLE_GAP + 1);
  localparam int KW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, PRE, SYN, LEN, PAY, CHK} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   count, count_n;
  logic [GW-1:0]   gap, gap_n;
  logic [7:0]      chk, chk_n;       // running XOR of accepted payload bytes
  logic [7:0]      sh, sh_n;         // byte on air; bit 0 is the current line value
  logic [2:0]      bit_cnt, bit_n;
  logic [KW-1:0]   clk_cnt, clk_n;
  logic [IW-1:0]   idx, idx_n;
  logic            busy_n, done_n, ovf_n, wr_en;
  logic [7:0]      pbuf [PAYLOAD_MAX];

  assign rif.tx_active = (state != IDLE);
  assign rif.tx_bit    = (state == IDLE) ? 1'b1 : sh[0];

  always_comb begin
    state_n = state;
    count_n = count;
    gap_n   = gap;
    chk_n   = chk;
    sh_n    = sh;
    bit_n   = bit_cnt;
    clk_n   = clk_cnt;
    idx_n   = idx;
    done_n  = 1'b0;
    wr_en   = 1'b0;
    // busy is the registered flag, so a send in the cycle busy falls is still dropped
    ovf_n   = rif.radio_enable & rif.radio_send & rif.radio_busy;
    case (state)
      IDLE: begin
        if (rif.radio_enable) begin
          // busy=0 in IDLE implies count < PAYLOAD_MAX
          if (rif.radio_send && !rif.radio_busy) begin
            wr_en   = 1'b1;
            count_n = count + 1'b1;
            chk_n   = chk ^ rif.radio_tx_data;
            gap_n   = '0;
          end else if (gap == GW'(IDLE_GAP) || count == CW'(PAYLOAD_MAX)) begin
            state_n = PRE;
            sh_n    = PREAMBLE;
            bit_n   = '0;
            clk_n   = '0;
            idx_n   = '0;
            gap_n   = '0;
          end else if (count != '0) begin
            gap_n = gap + 1'b1;
          end
        end
      end
      default: begin
        if (!rif.radio_enable) begin
          // abort: discard frame and buffer, no frame_done
          state_n = IDLE;
          count_n = '0;
          chk_n   = '0;
        end else if (clk_cnt == KW'(CLKS_PER_BIT - 1)) begin
          clk_n = '0;
          if (bit_cnt == 3'd7) begin
            bit_n = '0;
            case (state)
              PRE: begin state_n = SYN; sh_n = SYNC;      end
              SYN: begin state_n = LEN; sh_n = 8'(count); end
              LEN: begin state_n = PAY; sh_n = pbuf[0]; idx_n = '0; end
              PAY: begin
                if (CW'(idx) == count - CW'(1)) begin
                  state_n = CHK;
                  sh_n    = chk ^ 8'(count);
                end else begin
                  idx_n = IW'(idx + 1'b1);
                  sh_n  = pbuf[IW'(idx + 1'b1)];
                end
              end
              CHK: begin
                state_n = IDLE;
                done_n  = 1'b1;
                count_n = '0;
                chk_n   = '0;
              end
              default: state_n = IDLE;
            endcase
          end else begin
            bit_n = bit_cnt + 3'd1;
            sh_n  = {1'b1, sh[7:1]};
          end
        end else begin
          clk_n = clk_cnt + 1'b1;
        end
      end
    endcase
    // computed from next-state values so busy rises on the launch/fill edge
    busy_n = (state_n != IDLE) || (count_n == CW'(PAYLOAD_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      count          <= '0;
      gap            <= '0;
      chk            <= '0;
      sh             <= '1;
      bit_cnt        <= '0;
      clk_cnt        <= '0;
      idx            <= '0;
      rif.radio_busy <= 1'b0;
      rif.frame_done <= 1'b0;
      rif.overflow   <= 1'b0;
    end else begin
      state          <= state_n;
      count          <= count_n;
      gap            <= gap_n;
      chk            <= chk_n;
      sh             <= sh_n;
      bit_cnt        <= bit_n;
      clk_cnt        <= clk_n;
      idx            <= idx_n;
      rif.radio_busy <= busy_n;
      rif.frame_done <= done_n;
      rif.overflow   <= ovf_n;
    end
  end

  // payload storage needs no reset: count gates every read
  always_ff @(posedge clk) begin
    if (wr_en) pbuf[IW'(count)] <= rif.radio_tx_data;
  end
endmodule
